// File: rtl/pulse_pair_generator_fsm_pkg.sv
// Shared definitions for the pulse-pair generator.
// Contents:
//   CNT_W_DEF / REP_W_DEF : default widths of interval values and repeat count
//   state_t, ST_*         : 3-bit FSM state encoding
package pulse_pair_generator_fsm_pkg;

    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned REP_W_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_RSTCAP = 3'd1;
    localparam state_t ST_START  = 3'd2;
    localparam state_t ST_DELAY  = 3'd3;
    localparam state_t ST_GAP    = 3'd4;

endpackage

// File: rtl/pulse_pair_generator_fsm_if.sv
// Request/pulse bundle between a sequencer client and the pulse-pair generator.
// Signals (direction as seen by the generator, i.e. the slave modport):
//   trigger_i, abort_i        : single-cycle start / stop requests
//   delay_i, gap_i, repeat_i  : sequence parameters, sampled at acceptance
//   start_o, capture_o        : timing pulses towards the capture path
//   rst_capture_o             : clears the downstream capture register
//   busy_o, done_o            : sequence status
//   pairs_sent_o              : completed pair count
interface pulse_pair_generator_fsm_if
    import pulse_pair_generator_fsm_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned REP_W = REP_W_DEF
) ();

    logic             trigger_i;
    logic             abort_i;
    logic [CNT_W-1:0] delay_i;
    logic [CNT_W-1:0] gap_i;
    logic [REP_W-1:0] repeat_i;
    logic             start_o;
    logic             capture_o;
    logic             rst_capture_o;
    logic             busy_o;
    logic             done_o;
    logic [REP_W-1:0] pairs_sent_o;

    modport master (
        output trigger_i, abort_i, delay_i, gap_i, repeat_i,
        input  start_o, capture_o, rst_capture_o, busy_o, done_o, pairs_sent_o
    );

    modport slave (
        input  trigger_i, abort_i, delay_i, gap_i, repeat_i,
        output start_o, capture_o, rst_capture_o, busy_o, done_o, pairs_sent_o
    );

endinterface

// File: rtl/pulse_pair_generator_fsm_interval_down_counter.sv
// Loadable down counter shared by the delay and gap phases.
// Ports:
//   clk_i, rst_an_i : clock, asynchronous active-low reset
//   i_load          : load i_load_val (has priority over i_dec)
//   i_dec           : decrement; holds at zero so it can never wrap
//   o_count         : current count
//   o_zero          : current count is zero
//   o_zero_next     : count will be zero in the next cycle
module interval_down_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_an_i,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero,
    output logic             o_zero_next
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_load) begin
            w_count_next = i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count     = r_count;
    assign o_zero      = (r_count == '0);
    assign o_zero_next = (w_count_next == '0);

endmodule

// File: rtl/pulse_pair_generator_fsm.sv
// Start/capture pulse-pair sequencer for the timing-capture path.
// On an accepted trigger it emits rst_capture, then R start/capture pairs with
// start->capture spacing D and capture->start spacing G, then a done pulse.
// Ports:
//   clk_i    : system clock
//   rst_an_i : asynchronous active-low reset
//   io_bus   : request/pulse bundle (slave side), see pulse_pair_generator_fsm_if
module pulse_pair_generator_fsm
    import pulse_pair_generator_fsm_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned REP_W = REP_W_DEF
) (
    input  logic                              clk_i,
    input  logic                              rst_an_i,
    pulse_pair_generator_fsm_if.slave         io_bus
);

    state_t           r_state;
    state_t           w_state_next;

    // Sequence parameters latched at acceptance
    logic [CNT_W-1:0] r_delay_m1;
    logic [CNT_W-1:0] r_gap;
    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] r_pairs;

    logic             r_start;
    logic             r_capture;
    logic             r_rstcap;
    logic             r_busy;
    logic             r_done;

    logic             w_start_d;
    logic             w_capture_d;
    logic             w_rstcap_d;
    logic             w_busy_d;
    logic             w_done_d;
    logic [REP_W-1:0] w_pairs_d;

    logic             w_accept;
    logic             w_last;
    logic             w_abort;
    logic             w_capture_now;

    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_zero;
    logic             w_cnt_zero_next;

    interval_down_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i       (clk_i),
        .rst_an_i    (rst_an_i),
        .i_load      (w_cnt_load),
        .i_load_val  (w_cnt_val),
        .i_dec       (w_cnt_dec),
        .o_count     (w_cnt),
        .o_zero      (w_cnt_zero),
        .o_zero_next (w_cnt_zero_next)
    );

    assign w_accept = (r_state == ST_IDLE) && io_bus.trigger_i && !io_bus.abort_i &&
                      (io_bus.repeat_i != '0);
    assign w_abort  = (r_state != ST_IDLE) && io_bus.abort_i;
    // r_rep is never 0 inside a sequence, so r_rep-1 is the index of the final pair
    assign w_last   = (r_pairs == (r_rep - REP_W'(1)));
    // The capture pulse is visible in the cycle the delay counter sits at zero
    assign w_capture_now = (r_state == ST_DELAY) && w_cnt_zero;

    // State register
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and counter control
    always_comb begin
        w_state_next = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_val    = '0;
        w_cnt_dec    = 1'b0;
        if (w_abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_next = ST_RSTCAP;
                    end
                end
                ST_RSTCAP: begin
                    w_state_next = ST_START;
                end
                ST_START: begin
                    w_state_next = ST_DELAY;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = r_delay_m1;
                end
                ST_DELAY: begin
                    if (w_cnt_zero) begin
                        if (w_last) begin
                            w_state_next = ST_IDLE;
                        end else if (r_gap == CNT_W'(1)) begin
                            // Minimum gap: the capture cycle itself is the whole gap
                            w_state_next = ST_START;
                        end else begin
                            // Capture cycle counts as the first gap cycle
                            w_state_next = ST_GAP;
                            w_cnt_load   = 1'b1;
                            w_cnt_val    = r_gap - CNT_W'(2);
                        end
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_cnt_zero) begin
                        w_state_next = ST_START;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Output next values, decoded from where the FSM will be next cycle so the
    // flops present each pulse in the same cycle as its state.
    always_comb begin
        w_start_d   = (w_state_next == ST_START);
        w_rstcap_d  = (w_state_next == ST_RSTCAP);
        w_capture_d = (w_state_next == ST_DELAY) && w_cnt_zero_next;
        w_busy_d    = (w_state_next != ST_IDLE);
        w_done_d    = w_capture_now && w_last && !w_abort;
        w_pairs_d   = r_pairs;
        if (w_accept) begin
            w_pairs_d = '0;
        end else if (w_capture_now && !w_abort && (r_pairs != r_rep)) begin
            w_pairs_d = r_pairs + REP_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            r_start   <= 1'b0;
            r_capture <= 1'b0;
            r_rstcap  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pairs   <= '0;
        end else begin
            r_start   <= w_start_d;
            r_capture <= w_capture_d;
            r_rstcap  <= w_rstcap_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_pairs   <= w_pairs_d;
        end
    end

    // Parameter capture; zero delay/gap are promoted to one cycle
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            r_delay_m1 <= '0;
            r_gap      <= CNT_W'(1);
            r_rep      <= '0;
        end else if (w_accept) begin
            r_delay_m1 <= (io_bus.delay_i == '0) ? '0 : (io_bus.delay_i - CNT_W'(1));
            r_gap      <= (io_bus.gap_i == '0) ? CNT_W'(1) : io_bus.gap_i;
            r_rep      <= io_bus.repeat_i;
        end
    end

    assign io_bus.start_o       = r_start;
    assign io_bus.capture_o     = r_capture;
    assign io_bus.rst_capture_o = r_rstcap;
    assign io_bus.busy_o        = r_busy;
    assign io_bus.done_o        = r_done;
    assign io_bus.pairs_sent_o  = r_pairs;

endmodule

// File: tb/tb_pulse_pair_generator_fsm.sv
// Directed self-checking bench for pulse_pair_generator_fsm (CNT_W=8 build).
// Offsets below count cycles after the accepting edge k (offset 1 = cycle k+1).
module tb_pulse_pair_generator_fsm;

    localparam int unsigned CW = 8;
    localparam int unsigned RW = 8;

    logic clk;
    logic rst_an;
    int   n_cmp;
    int   n_fail;

    // Downstream capture-path model: counts cycles strictly between start and capture
    logic [31:0] meas;
    logic        meas_run;

    pulse_pair_generator_fsm_if #(.CNT_W(CW), .REP_W(RW)) bus_if ();

    pulse_pair_generator_fsm #(
        .CNT_W (CW),
        .REP_W (RW)
    ) dut (
        .clk_i    (clk),
        .rst_an_i (rst_an),
        .io_bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            meas     <= '0;
            meas_run <= 1'b0;
        end else if (bus_if.rst_capture_o) begin
            meas     <= '0;
            meas_run <= 1'b0;
        end else if (bus_if.start_o) begin
            meas     <= '0;
            meas_run <= 1'b1;
        end else if (bus_if.capture_o) begin
            meas_run <= 1'b0;
        end else if (meas_run) begin
            meas     <= meas + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, bus_if.start_o, bus_if.capture_o, bus_if.rst_capture_o,
                bus_if.busy_o, bus_if.done_o};
    endfunction

    task automatic idle_check(input string tag, input int exp_pairs, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_outs"}, outs(), 32'd0);
            chk({tag, "_pairs"}, {24'd0, bus_if.pairs_sent_o}, exp_pairs);
            tick();
        end
    endtask

    // Drive a trigger, let edge k accept it, then scramble the parameters
    task automatic start_seq(input int d, input int g, input int r);
        bus_if.delay_i   = CW'(d);
        bus_if.gap_i     = CW'(g);
        bus_if.repeat_i  = RW'(r);
        bus_if.trigger_i = 1'b1;
        tick();
        bus_if.trigger_i = 1'b0;
        bus_if.delay_i   = CW'($urandom);
        bus_if.gap_i     = CW'($urandom);
        bus_if.repeat_i  = RW'($urandom);
    endtask

    // Check offsets j_from..j_to of a sequence with effective D, G, R
    task automatic seq_check(input string tag, input int d, input int g, input int r,
                             input int j_from, input int j_to);
        for (int j = j_from; j <= j_to; j++) begin
            int p_len;
            int t_done;
            int e_pairs;
            logic e_st, e_cap, e_rst, e_busy, e_done;
            p_len   = d + g;
            t_done  = 2 + (r - 1) * p_len + d + 1;
            e_st    = (j >= 2) && ((j - 2) % p_len == 0) && ((j - 2) / p_len < r);
            e_cap   = (j >= 2 + d) && ((j - 2 - d) % p_len == 0) && ((j - 2 - d) / p_len < r);
            e_rst   = (j == 1);
            e_busy  = (j >= 1) && (j < t_done);
            e_done  = (j == t_done);
            if (j <= 2 + d) e_pairs = 0;
            else begin
                e_pairs = (j - 3 - d) / p_len + 1;
                if (e_pairs > r) e_pairs = r;
            end
            chk($sformatf("%s_outs@%0d", tag, j), outs(),
                {27'd0, e_st, e_cap, e_rst, e_busy, e_done});
            chk($sformatf("%s_pairs@%0d", tag, j), {24'd0, bus_if.pairs_sent_o}, e_pairs);
            tick();
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_an = 1'b0;
        bus_if.trigger_i = 1'b0;
        bus_if.abort_i   = 1'b0;
        bus_if.delay_i   = '0;
        bus_if.gap_i     = '0;
        bus_if.repeat_i  = '0;

        tick();
        tick();
        chk("in_reset", outs(), 32'd0);
        chk("in_reset_pairs", {24'd0, bus_if.pairs_sent_o}, 32'd0);
        rst_an = 1'b1;
        idle_check("idle20", 0, 20);

        // D=5 G=3 R=1: rst_cap +1, start +2, capture +7, done +8
        start_seq(5, 3, 1);
        seq_check("t1", 5, 3, 1, 1, 10);
        chk("t1_cap_path", meas, 32'd4);

        // D=0,G=0 -> 1,1; R=3: starts +2/+4/+6, captures +3/+5/+7, done +8
        start_seq(0, 0, 3);
        seq_check("t2", 1, 1, 3, 1, 7);
        // Retrigger in the done cycle is accepted at the following edge
        bus_if.delay_i   = CW'(2);
        bus_if.gap_i     = CW'(0);
        bus_if.repeat_i  = RW'(1);
        bus_if.trigger_i = 1'b1;
        seq_check("t2", 1, 1, 3, 8, 8);
        bus_if.trigger_i = 1'b0;
        seq_check("t2b", 2, 1, 1, 1, 5);

        // D=100 R=2, abort in offset 50: nothing but zeros afterwards, pairs hold 0
        start_seq(100, 0, 2);
        seq_check("t3", 100, 1, 2, 1, 49);
        bus_if.abort_i = 1'b1;
        seq_check("t3", 100, 1, 2, 50, 50);
        bus_if.abort_i = 1'b0;
        idle_check("t3_abort", 0, 70);

        // Abort and trigger together while idle: abort wins
        bus_if.abort_i   = 1'b1;
        bus_if.trigger_i = 1'b1;
        bus_if.repeat_i  = RW'(2);
        bus_if.delay_i   = CW'(3);
        tick();
        bus_if.abort_i   = 1'b0;
        bus_if.trigger_i = 1'b0;
        idle_check("abort_trig", 0, 5);

        // repeat=0 trigger is ignored
        bus_if.repeat_i  = RW'(0);
        bus_if.trigger_i = 1'b1;
        tick();
        bus_if.trigger_i = 1'b0;
        idle_check("rep0", 0, 5);

        // Trigger while busy is ignored: D=5 G=2 R=2, stray trigger at offset 5
        start_seq(5, 2, 2);
        seq_check("t4", 5, 2, 2, 1, 4);
        bus_if.trigger_i = 1'b1;
        bus_if.repeat_i  = RW'(4);
        bus_if.delay_i   = CW'(1);
        seq_check("t4", 5, 2, 2, 5, 5);
        bus_if.trigger_i = 1'b0;
        seq_check("t4", 5, 2, 2, 6, 16);

        // Maximum delay for the 8-bit build: capture exactly 255 cycles after start
        start_seq(255, 0, 1);
        seq_check("t5", 255, 1, 1, 1, 259);

        // Asynchronous reset in the middle of a delay
        start_seq(200, 0, 1);
        seq_check("t6", 200, 1, 1, 1, 40);
        #3;
        rst_an = 1'b0;
        #1;
        chk("async_rst_outs", outs(), 32'd0);
        chk("async_rst_pairs", {24'd0, bus_if.pairs_sent_o}, 32'd0);
        tick();
        rst_an = 1'b1;
        idle_check("post_rst", 0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
